fs_dither_stream: RTL and testbench

FS_DITHER_STREAM -- requirements
Module: fs_dither_stream

---
 rtl/dither_pkg.sv | 12 +
 rtl/fs_err_linebuf.sv | 30 +++
 rtl/fs_dither_stream.sv | 94 +++++++++
 tb/tb_fs_dither_stream.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dither_pkg.sv
// dither_pkg: frame FSM states and Floyd-Steinberg diffusion weights shared by the dither stream
package dither_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} dither_state_t;
  localparam int W_E = 7;
  localparam int W_SW = 3;
  localparam int W_S = 5;
  localparam int W_SE = 1;
  localparam int W_SHIFT = 4;
  function automatic int fs_share(input int e, input int w);
    return (e * w) >>> W_SHIFT;
  endfunction
endpackage

// File: rtl/fs_err_linebuf.sv
// fs_err_linebuf: one signed error entry per column, read for the current row and rebuilt for the next
module fs_err_linebuf #(
  parameter int IMAGEX = 64,
  parameter int EW = 11,
  localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 upd,
  input  logic [XW-1:0]        x,
  input  logic signed [EW-1:0] sw,
  input  logic signed [EW-1:0] s,
  input  logic signed [EW-1:0] se,
  output logic signed [EW-1:0] rd
);
  logic signed [EW-1:0] mem [IMAGEX];
  logic signed [EW-1:0] se_q;
  assign rd = mem[x];
  // entry x is consumed this cycle, so it is overwritten with next-row data; x-1 only gains the SW share
  always_ff @(posedge clk)
    if (upd) begin
      mem[x] <= se_q + s;
      if (x != '0) mem[x - 1'b1] <= mem[x - 1'b1] + sw;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) se_q <= '0;
    else if (clr) se_q <= '0;
    else if (upd) se_q <= (x == XW'(IMAGEX - 1)) ? '0 : se;
endmodule

// File: rtl/fs_dither_stream.sv
// fs_dither_stream: streaming Floyd-Steinberg ditherer, one pixel per handshake with a registered output stage
module fs_dither_stream
  import dither_pkg::*;
#(
  parameter int IMAGEX = 64,
  parameter int IMAGEY = 64,
  parameter int PIX_W = 8,
  parameter int OUT_BITS = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                bypass,
  input  logic [PIX_W-1:0]    in_pix,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [OUT_BITS-1:0] out_lvl,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                frame_done
);
  localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
  localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
  localparam int EW = PIX_W + 3;
  dither_state_t state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic byp_q, acc, last_col, last_row;
  logic signed [EW-1:0] east_q, rd, east_eff, row_eff, c, e, sh_e, sh_sw, sh_s, sh_se;
  logic [PIX_W-1:0] c_sat, r;
  logic [OUT_BITS-1:0] lvl;
  assign busy = state == RUN;
  assign frame_done = state == DONE;
  assign in_ready = busy && (out_ready || !out_valid);
  assign acc = in_valid && in_ready;
  assign last_col = x == XW'(IMAGEX - 1);
  assign last_row = y == YW'(IMAGEY - 1);
  // row 0 ignores stale entries left by the previous frame
  assign east_eff = byp_q ? '0 : east_q;
  assign row_eff = (byp_q || y == '0) ? '0 : rd;
  assign c = $signed({3'b000, in_pix}) + east_eff + row_eff;
  assign c_sat = c[EW-1] ? '0 : ((|c[EW-2:PIX_W]) ? '1 : c[PIX_W-1:0]);
  assign lvl = c_sat[PIX_W-1 -: OUT_BITS];
  always_comb begin
    r = '0;
    for (int i = 0; i < PIX_W; i++) r[PIX_W-1-i] = lvl[OUT_BITS-1-(i % OUT_BITS)];
  end
  assign e = $signed({3'b000, c_sat}) - $signed({3'b000, r});
  assign sh_e = EW'(fs_share(int'(e), W_E));
  assign sh_sw = EW'(fs_share(int'(e), W_SW));
  assign sh_s = EW'(fs_share(int'(e), W_S));
  assign sh_se = EW'(fs_share(int'(e), W_SE));
  fs_err_linebuf #(.IMAGEX(IMAGEX), .EW(EW)) u_linebuf (
    .clk(clk),
    .rst(rst),
    .clr(start && state == IDLE),
    .upd(acc && !last_row),
    .x(x),
    .sw(sh_sw),
    .s(sh_s),
    .se(sh_se),
    .rd(rd)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      x <= '0;
      y <= '0;
      east_q <= '0;
      byp_q <= 1'b0;
      out_lvl <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= acc || (out_valid && !out_ready);
      if (acc) out_lvl <= lvl;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          x <= '0;
          y <= '0;
          east_q <= '0;
          byp_q <= bypass;
        end
        RUN: if (acc) begin
          x <= last_col ? '0 : x + 1'b1;
          y <= last_col ? y + 1'b1 : y;
          east_q <= last_col ? '0 : sh_e;
          if (last_col && last_row) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fs_dither_stream.sv
// tb_fs_dither_stream: random and directed frames checked against a 2-D error-array dither model
module tb_fs_dither_stream;
  localparam int IX = 4;
  localparam int IY = 3;
  localparam int NPIX = IX * IY;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bypass = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0] in_pix = '0;
  logic in_ready, out_valid, busy, frame_done;
  logic [0:0] out_lvl;
  logic st2 = 1'b0, iv2 = 1'b0, or2 = 1'b1, byp2 = 1'b0;
  logic [7:0] ip2 = '0;
  logic ir2, ov2, bz2, fd2;
  logic [1:0] lvl2;
  int checks = 0, errors = 0, fd_cnt = 0;
  int pix_a [NPIX];
  int exp_a [NPIX];
  int got[$], got2[$];
  bit rnd_rdy = 1'b0, hold_v = 1'b0;
  logic [0:0] hold_l;

  fs_dither_stream #(.IMAGEX(IX), .IMAGEY(IY), .PIX_W(8), .OUT_BITS(1)) dut (
    .clk(clk), .rst(rst), .start(start), .bypass(bypass), .in_pix(in_pix), .in_valid(in_valid),
    .in_ready(in_ready), .out_lvl(out_lvl), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done)
  );
  fs_dither_stream #(.IMAGEX(IX), .IMAGEY(IY), .PIX_W(8), .OUT_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .start(st2), .bypass(byp2), .in_pix(ip2), .in_valid(iv2),
    .in_ready(ir2), .out_lvl(lvl2), .out_valid(ov2), .out_ready(or2),
    .busy(bz2), .frame_done(fd2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // classic Floyd-Steinberg over a full error image; levels rebuilt as l*255/(2^ob-1)
  function automatic void model(input bit byp, input int ob);
    int err [IY][IX];
    int c, l, r, e, top;
    top = (1 << ob) - 1;
    foreach (err[a, b]) err[a][b] = 0;
    for (int y = 0; y < IY; y++)
      for (int x = 0; x < IX; x++) begin
        c = pix_a[y*IX+x] + (byp ? 0 : err[y][x]);
        c = c < 0 ? 0 : (c > 255 ? 255 : c);
        l = c >> (8 - ob);
        r = l * 255 / top;
        e = c - r;
        exp_a[y*IX+x] = l;
        if (!byp) begin
          if (x < IX-1) err[y][x+1] += (e * 7) >>> 4;
          if (y < IY-1) begin
            if (x > 0) err[y+1][x-1] += (e * 3) >>> 4;
            err[y+1][x] += (e * 5) >>> 4;
            if (x < IX-1) err[y+1][x+1] += (e * 1) >>> 4;
          end
        end
      end
  endfunction

  function automatic void fill(input int v);
    for (int i = 0; i < NPIX; i++) pix_a[i] = v < 0 ? int'($urandom_range(0, 255)) : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
  endtask

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (ov2 && or2) got2.push_back(int'(lvl2));
    if (rst) hold_v = 1'b0;
    else begin
      if (out_valid && out_ready) got.push_back(int'(out_lvl));
      if (out_valid && !out_ready) chk("in_ready_stall", int'(in_ready), 0);
      if (hold_v) chk("hold", int'({out_valid, out_lvl}), int'({1'b1, hold_l}));
      hold_v = out_valid && !out_ready;
      hold_l = out_lvl;
    end
  end

  task automatic run_frame(input bit byp, input bit rr, input int mid_start, input int abort_at);
    int k, g;
    rnd_rdy = rr;
    got.delete();
    fd_cnt = 0;
    bypass = byp;
    start = 1'b1;
    tick();
    start = 1'b0;
    bypass = 1'b0;
    k = 0;
    g = 0;
    while (k < NPIX && k != abort_at && g < 4000) begin
      in_pix = 8'(pix_a[k]);
      in_valid = ($urandom_range(0, 3) != 0);
      start = (k == mid_start);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      tick();
      g++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (abort_at >= 0) return;
    chk("feed", k, NPIX);
    g = 0;
    while (got.size() < NPIX && g < 500) begin
      tick();
      g++;
    end
    rnd_rdy = 1'b0;
    repeat (3) tick();
    chk("count", got.size(), NPIX);
    chk("frame_done", fd_cnt, 1);
    chk("busy_end", int'(busy), 0);
    model(byp, 1);
    for (int i = 0; i < NPIX; i++) chk($sformatf("lvl%0d", i), i < got.size() ? got[i] : -1, exp_a[i]);
  endtask

  task automatic run_frame2();
    int k, g;
    got2.delete();
    st2 = 1'b1;
    tick();
    st2 = 1'b0;
    iv2 = 1'b1;
    k = 0;
    g = 0;
    while (k < NPIX && g < 200) begin
      ip2 = 8'(pix_a[k]);
      @(negedge clk);
      if (ir2) k++;
      tick();
      g++;
    end
    iv2 = 1'b0;
    repeat (4) tick();
    chk("count2", got2.size(), NPIX);
    model(1'b0, 2);
    for (int i = 0; i < NPIX; i++) chk($sformatf("lvl2_%0d", i), i < got2.size() ? got2[i] : -1, exp_a[i]);
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_out_lvl", int'(out_lvl), 0);
    rst = 1'b0;
    tick();
    fill(128);
    run_frame(1'b0, 1'b0, -1, -1);
    chk("r0_x0", got[0], 1);
    chk("r0_x1", got[1], 0);
    chk("r0_x2", got[2], 1);
    chk("r0_x3", got[3], 0);
    fill(0);
    run_frame(1'b0, 1'b0, -1, -1);
    fill(255);
    run_frame(1'b0, 1'b0, -1, -1);
    fill(128);
    run_frame(1'b1, 1'b0, -1, -1);
    fill(128);
    run_frame(1'b0, 1'b1, -1, -1);
    fill(-1);
    run_frame(1'b0, 1'b1, 6, -1);
    fill(-1);
    run_frame(1'b0, 1'b1, -1, -1);
    fill(-1);
    run_frame(1'b1, 1'b1, -1, -1);
    fill(-1);
    run_frame(1'b0, 1'b0, -1, 5);
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    fill(128);
    run_frame(1'b0, 1'b0, -1, -1);
    chk("rr0_x0", got[0], 1);
    chk("rr0_x1", got[1], 0);
    chk("rr0_x2", got[2], 1);
    chk("rr0_x3", got[3], 0);
    fill(8'h55);
    run_frame2();
    chk("ob2_first", got2.size() > 0 ? got2[0] : -1, 1);
    fill(-1);
    run_frame2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
